// File: rtl/instr_imm_field_decode_if.sv
// instr_imm_field_decode_if
//   Bundles the fetch-side and execute-side handshakes of the decode slice.
//   Signals:
//     IN_VALID / IN_READY / IN_INSTR   fetch -> decode instruction handshake
//     OUT_VALID / OUT_READY            decode -> execute handshake
//     OP2_0, Imm_7, Imm_5, Shamt_5,
//     KIND                             decoded fields for the ALU src-2 extender
//   Modports:
//     master : the environment (drives instructions, consumes results)
//     slave  : the decode block
interface instr_imm_field_decode_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OP2_0;
  logic [6:0]  Imm_7;
  logic [4:0]  Imm_5;
  logic [4:0]  Shamt_5;
  logic [1:0]  KIND;

  modport master (
    output IN_VALID, IN_INSTR, OUT_READY,
    input  IN_READY, OUT_VALID, OP2_0, Imm_7, Imm_5, Shamt_5, KIND
  );

  modport slave (
    input  IN_VALID, IN_INSTR, OUT_READY,
    output IN_READY, OUT_VALID, OP2_0, Imm_7, Imm_5, Shamt_5, KIND
  );
endinterface

// File: rtl/instr_imm_field_decode.sv
// instr_imm_field_decode
//   Decode-stage slice: classifies RV32I stores and shift-immediates and
//   splits them into the fields used by the ALU source-2 extender. A
//   registered output stage (OREG) plus a one-entry skid buffer (SKID) lets
//   fetch and execute stall independently; ordering is strictly FIFO.
//   Ports:
//     CLK        clock, rising edge
//     RST_N      synchronous active-low reset
//     bus        instr_imm_field_decode_if.slave (handshakes + decoded fields)
//   Optional feature, macro DECODE_STATS_EN:
//     STATS_CLR  input, synchronous clear of the counters (beats increments)
//     STORE_CNT, SHIFT_CNT, ILLEGAL_CNT  16-bit saturating consume counters
module instr_imm_field_decode (
  input  logic                           CLK,
  input  logic                           RST_N,
  instr_imm_field_decode_if.slave        bus
`ifdef DECODE_STATS_EN
  ,
  input  logic                           STATS_CLR,
  output logic [15:0]                    STORE_CNT,
  output logic [15:0]                    SHIFT_CNT,
  output logic [15:0]                    ILLEGAL_CNT
`endif
);

  typedef struct packed {
    logic       op2;
    logic [1:0] kind;
    logic [6:0] imm7;
    logic [4:0] imm5;
    logic [4:0] shamt;
  } dec_t;

  // Encoding is {OREG valid, SKID valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;
  dec_t   oreg_q, oreg_d;
  dec_t   skid_q, skid_d;
  dec_t   dec;
  logic   oreg_v, skid_v;
  logic   accept, consume;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------
  always_comb begin
    dec       = '0;
    dec.imm7  = bus.IN_INSTR[31:25];
    dec.imm5  = bus.IN_INSTR[11:7];
    dec.shamt = bus.IN_INSTR[24:20];
    case (bus.IN_INSTR[6:0])
      7'b0100011: dec.kind = 2'b01;
      7'b0010011: begin
        case (bus.IN_INSTR[14:12])
          3'b001:  dec.kind = (bus.IN_INSTR[31:25] == 7'b0000000) ? 2'b10 : 2'b11;
          3'b101:  dec.kind = ((bus.IN_INSTR[31:25] == 7'b0000000) ||
                               (bus.IN_INSTR[31:25] == 7'b0100000)) ? 2'b10 : 2'b11;
          default: dec.kind = 2'b00;
        endcase
      end
      default: dec.kind = 2'b00;
    endcase
    dec.op2 = (dec.kind == 2'b10);
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign oreg_v  = state_q[1];
  assign skid_v  = state_q[0];
  // IN_READY comes straight from the SKID valid flop, so there is no
  // combinational path from OUT_READY back to fetch.
  assign accept  = bus.IN_VALID && !skid_v;
  assign consume = oreg_v && bus.OUT_READY;

  // ---------------------------------------------------------------------
  // Next-state and datapath steering
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    oreg_d  = oreg_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          oreg_d  = dec;
        end
      end
      HALF: begin
        if (accept && consume) begin
          oreg_d = dec;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = dec;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // IN_READY is low here, so only a consume can move the state.
        if (consume) begin
          state_d = HALF;
          oreg_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      oreg_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      oreg_q  <= oreg_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.IN_READY  = !skid_v;
  assign bus.OUT_VALID = oreg_v;
  assign bus.OP2_0     = oreg_q.op2;
  assign bus.KIND      = oreg_q.kind;
  assign bus.Imm_7     = oreg_q.imm7;
  assign bus.Imm_5     = oreg_q.imm5;
  assign bus.Shamt_5   = oreg_q.shamt;

`ifdef DECODE_STATS_EN
  // ---------------------------------------------------------------------
  // Saturating consume counters; clear wins over a same-cycle increment
  // ---------------------------------------------------------------------
  logic [15:0] store_cnt_q, store_cnt_d;
  logic [15:0] shift_cnt_q, shift_cnt_d;
  logic [15:0] ill_cnt_q,   ill_cnt_d;

  always_comb begin
    store_cnt_d = store_cnt_q;
    shift_cnt_d = shift_cnt_q;
    ill_cnt_d   = ill_cnt_q;
    if (STATS_CLR) begin
      store_cnt_d = '0;
      shift_cnt_d = '0;
      ill_cnt_d   = '0;
    end else if (consume) begin
      case (oreg_q.kind)
        2'b01: if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 16'd1;
        2'b10: if (shift_cnt_q != '1) shift_cnt_d = shift_cnt_q + 16'd1;
        2'b11: if (ill_cnt_q   != '1) ill_cnt_d   = ill_cnt_q   + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      store_cnt_q <= '0;
      shift_cnt_q <= '0;
      ill_cnt_q   <= '0;
    end else begin
      store_cnt_q <= store_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign STORE_CNT   = store_cnt_q;
  assign SHIFT_CNT   = shift_cnt_q;
  assign ILLEGAL_CNT = ill_cnt_q;
`endif

endmodule

// File: tb/tb_instr_imm_field_decode.sv
// tb_instr_imm_field_decode
//   Self-checking bench: reset values, a table of known encodings, handshake
//   corner sequences (backpressure, reset while full) and a randomized run
//   against a queue-based reference model. Counter checks are compiled in
//   when DECODE_STATS_EN is defined.
module tb_instr_imm_field_decode;

  logic CLK;
  logic RST_N;
  instr_imm_field_decode_if bus ();

`ifdef DECODE_STATS_EN
  logic        STATS_CLR;
  logic [15:0] STORE_CNT, SHIFT_CNT, ILLEGAL_CNT;
`endif

  instr_imm_field_decode dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus)
`ifdef DECODE_STATS_EN
    ,
    .STATS_CLR  (STATS_CLR),
    .STORE_CNT  (STORE_CNT),
    .SHIFT_CNT  (SHIFT_CNT),
    .ILLEGAL_CNT(ILLEGAL_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_store = 0, m_shift = 0, m_ill = 0;
  logic        stats_clr_m = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  kind;
    logic        op2;
    logic [6:0]  imm7;
    logic [4:0]  imm5;
    logic [4:0]  shamt;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Classification straight from the ISA rules
  function automatic logic [1:0] ref_kind(input logic [31:0] w);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    if (opc == 7'h23) return 2'd1;
    if (opc == 7'h13 && f3 == 3'd1) return (f7 == 7'h00) ? 2'd2 : 2'd3;
    if (opc == 7'h13 && f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? 2'd2 : 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h23;
      1, 2: begin
        w[6:0]   = 7'h13;
        w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      3: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: apply inputs, clock, advance the model, settle 1 time unit.
  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic rstn);
    bit cons, acc;
    logic [1:0] k;
    bus.IN_VALID = v;
    bus.IN_INSTR = w;
    bus.OUT_READY = r;
    RST_N = rstn;
    @(posedge CLK);
    if (!rstn) begin
      mq.delete();
      m_store = 0; m_shift = 0; m_ill = 0;
    end else begin
      cons = (mq.size() > 0) && r;
      acc  = v && (mq.size() < 2);
      if (stats_clr_m) begin
        m_store = 0; m_shift = 0; m_ill = 0;
      end else if (cons) begin
        k = ref_kind(mq[0]);
        if (k == 2'd1 && m_store < 65535) m_store++;
        if (k == 2'd2 && m_shift < 65535) m_shift++;
        if (k == 2'd3 && m_ill   < 65535) m_ill++;
      end
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
    #1;
  endtask

  task automatic check_model();
    logic [1:0] k;
    chk("in_ready", {31'd0, bus.IN_READY}, {31'd0, mq.size() < 2});
    chk("out_valid", {31'd0, bus.OUT_VALID}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      k = ref_kind(mq[0]);
      chk("kind", {30'd0, bus.KIND}, {30'd0, k});
      chk("op2_0", {31'd0, bus.OP2_0}, {31'd0, k == 2'd2});
      chk("imm_7", {25'd0, bus.Imm_7}, {25'd0, mq[0][31:25]});
      chk("imm_5", {27'd0, bus.Imm_5}, {27'd0, mq[0][11:7]});
      chk("shamt_5", {27'd0, bus.Shamt_5}, {27'd0, mq[0][24:20]});
    end
`ifdef DECODE_STATS_EN
    chk("store_cnt", {16'd0, STORE_CNT}, m_store);
    chk("shift_cnt", {16'd0, SHIFT_CNT}, m_shift);
    chk("illegal_cnt", {16'd0, ILLEGAL_CNT}, m_ill);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.OUT_VALID}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.IN_READY}, 32'd1);
    chk({tag, "_fields"}, {12'd0, bus.OP2_0, bus.KIND, bus.Imm_7, bus.Imm_5, bus.Shamt_5}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    tbl[0] = '{32'h00512423, 2'b01, 1'b0, 7'h00, 5'd8,  5'd5};
    tbl[1] = '{32'h40305093, 2'b10, 1'b1, 7'h20, 5'd1,  5'd3};
    tbl[2] = '{32'h60305093, 2'b11, 1'b0, 7'h30, 5'd1,  5'd3};
    tbl[3] = '{32'h00000033, 2'b00, 1'b0, 7'h00, 5'd0,  5'd0};
    tbl[4] = '{32'h01f09093, 2'b10, 1'b1, 7'h00, 5'd1,  5'd31};
    tbl[5] = '{32'h41f09093, 2'b11, 1'b0, 7'h20, 5'd1,  5'd31};
    tbl[6] = '{32'h0020d093, 2'b10, 1'b1, 7'h00, 5'd1,  5'd2};
    tbl[7] = '{32'h00108093, 2'b00, 1'b0, 7'h00, 5'd1,  5'd1};
    tbl[8] = '{32'hfe112e23, 2'b01, 1'b0, 7'h7f, 5'h1c, 5'd1};

    bus.IN_VALID = 1'b0;
    bus.IN_INSTR = '0;
    bus.OUT_READY = 1'b0;
    RST_N = 1'b0;
`ifdef DECODE_STATS_EN
    STATS_CLR = 1'b0;
`endif

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00512423, 1'b1, 1'b0);
    check_zero("reset");

    // Table of known encodings, streamed back to back with OUT_READY high
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].instr, 1'b1, 1'b1);
      chk("tbl_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
      chk("tbl_kind", {30'd0, bus.KIND}, {30'd0, tbl[i].kind});
      chk("tbl_op2_0", {31'd0, bus.OP2_0}, {31'd0, tbl[i].op2});
      chk("tbl_imm_7", {25'd0, bus.Imm_7}, {25'd0, tbl[i].imm7});
      chk("tbl_imm_5", {27'd0, bus.Imm_5}, {27'd0, tbl[i].imm5});
      chk("tbl_shamt_5", {27'd0, bus.Shamt_5}, {27'd0, tbl[i].shamt});
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);

    // Backpressure: A, B accepted, C waits, then A, B, C in order
    a = tbl[0].instr; b = tbl[1].instr; c = tbl[2].instr;
    step(1'b1, a, 1'b0, 1'b1);
    chk("bp_a_in_ready", {31'd0, bus.IN_READY}, 32'd1);
    chk("bp_a_shown", {25'd0, bus.Imm_7}, {25'd0, tbl[0].imm7});
    step(1'b1, b, 1'b0, 1'b1);
    chk("bp_full_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    step(1'b1, c, 1'b0, 1'b1);
    chk("bp_hold_kind", {30'd0, bus.KIND}, {30'd0, tbl[0].kind});
    chk("bp_hold_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    check_model();
    step(1'b1, c, 1'b1, 1'b1);
    chk("bp_b_kind", {30'd0, bus.KIND}, {30'd0, tbl[1].kind});
    chk("bp_b_in_ready", {31'd0, bus.IN_READY}, 32'd1);
    step(1'b1, c, 1'b1, 1'b1);
    chk("bp_c_kind", {30'd0, bus.KIND}, {30'd0, tbl[2].kind});
    chk("bp_c_imm_7", {25'd0, bus.Imm_7}, {25'd0, tbl[2].imm7});
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_empty", {31'd0, bus.OUT_VALID}, 32'd0);
    check_model();

    // Reset while FULL, then a store decodes normally
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    step(1'b1, c, 1'b1, 1'b0);
    check_zero("midrst");
    step(1'b1, tbl[8].instr, 1'b1, 1'b1);
    chk("post_rst_kind", {30'd0, bus.KIND}, 32'd1);
    chk("post_rst_imm_5", {27'd0, bus.Imm_5}, 32'h1c);
    check_model();
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        step(1'b1, rand_instr(), 1'b1, 1'b0);
        check_zero("rand_rst");
      end
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 9) < 6), 1'b1);
      check_model();
    end

`ifdef DECODE_STATS_EN
    // Saturation of the store counter, then clear beating an increment
    for (int n = 0; n < 65545; n++) step(1'b1, tbl[0].instr, 1'b1, 1'b1);
    chk("store_cnt_sat", {16'd0, STORE_CNT}, 32'h0000ffff);
    check_model();
    STATS_CLR = 1'b1; stats_clr_m = 1'b1;
    step(1'b1, tbl[0].instr, 1'b1, 1'b1);
    STATS_CLR = 1'b0; stats_clr_m = 1'b0;
    chk("store_cnt_clr", {16'd0, STORE_CNT}, 32'd0);
    check_model();
    step(1'b1, tbl[1].instr, 1'b1, 1'b1);
    check_model();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
